// File: rtl/noc_axi_sched_pkg.sv
// rtl/noc_axi_sched_pkg.sv - shared types and type-word layout for the NoC AXI request scheduler
package noc_axi_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_RD_BURST = 2'd2,
      ST_WR_BURST = 2'd3
   } sched_state_e;

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } dir_e;

   localparam logic [1:0] MSG_TYPE_LOAD  = 2'd1;
   localparam logic [1:0] MSG_TYPE_STORE = 2'd2;

   localparam int TW_WIDTH         = 6;
   localparam int TW_FLIT_TYPE_LSB = 0;
   localparam int TW_READ_WORD_SEL = 2;
   localparam int TW_READ_SIZE     = 3;
   localparam int TW_LAST_READ     = 4;
   localparam int TW_LAST_WRITE    = 5;

   function automatic logic [TW_WIDTH-1:0] make_type_word(
      input logic is_write,
      input logic last_beat,
      input logic wide_bus,
      input logic word_sel
   );
      logic [TW_WIDTH-1:0] tw;
      tw = '0;
      tw[TW_FLIT_TYPE_LSB +: 2] = is_write ? MSG_TYPE_STORE : MSG_TYPE_LOAD;
      tw[TW_LAST_WRITE]         = is_write & last_beat;
      tw[TW_LAST_READ]          = !is_write & last_beat;
      tw[TW_READ_SIZE]          = wide_bus;
      tw[TW_READ_WORD_SEL]      = !is_write & word_sel;
      return tw;
   endfunction

endpackage

// File: rtl/noc_axi_rr_arb.sv
// rtl/noc_axi_rr_arb.sv - two-requester round-robin arbiter (read vs write address channel)
module noc_axi_rr_arb
   import noc_axi_sched_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic rd_req,
   input  logic wr_req,
   input  logic update,
   output logic rd_gnt,
   output logic wr_gnt
);

   dir_e ptr_q;

   // Pointer names the preferred requester; a lone requester always wins.
   assign rd_gnt = rd_req & ((ptr_q == DIR_RD) | !wr_req);
   assign wr_gnt = wr_req & ((ptr_q == DIR_WR) | !rd_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= DIR_RD;
      end else if (update && rd_gnt) begin
         ptr_q <= DIR_WR;
      end else if (update && wr_gnt) begin
         ptr_q <= DIR_RD;
      end
   end

endmodule

// File: rtl/noc_axi_txn_scheduler.sv
// rtl/noc_axi_txn_scheduler.sv - arbitrates AXI AR/AW bursts into per-beat NoC request descriptors
module noc_axi_txn_scheduler
   import noc_axi_sched_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_LEN_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [AXI_LEN_WIDTH-1:0]  s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [AXI_LEN_WIDTH-1:0]  s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic [1:0]                req_type,
   output logic [AXI_ADDR_WIDTH-1:0] req_addr,
   output logic                      req_last,
   output logic                      type_wr,
   output logic [TW_WIDTH-1:0]       type_wr_data,
   input  logic                      type_fifo_full,
   input  logic                      previous_trans_complete
);

   localparam int   MAX_SIZE    = $clog2(AXI_DATA_WIDTH / 8);
   localparam logic WIDE_BUS    = (AXI_DATA_WIDTH == 128);
   localparam logic NARROW_BUS  = (AXI_DATA_WIDTH == 64);

   sched_state_e              state_q;
   dir_e                      dir_q;
   dir_e                      last_dir_q;
   dir_e                      hs_dir;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_LEN_WIDTH-1:0]  len_q;
   logic [AXI_LEN_WIDTH-1:0]  cnt_q;
   logic [2:0]                size_q;

   logic rd_gnt;
   logic wr_gnt;
   logic idle;
   logic in_burst;
   logic is_wr;
   logic ar_hs;
   logic aw_hs;
   logic fire;
   logic last_beat;

   noc_axi_rr_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_req (s_axi_arvalid),
      .wr_req (s_axi_awvalid),
      .update (ar_hs | aw_hs),
      .rd_gnt (rd_gnt),
      .wr_gnt (wr_gnt)
   );

   assign idle          = (state_q == ST_IDLE);
   assign in_burst      = (state_q == ST_RD_BURST) || (state_q == ST_WR_BURST);
   assign is_wr         = (state_q == ST_WR_BURST);
   assign s_axi_arready = idle & rd_gnt;
   assign s_axi_awready = idle & wr_gnt;
   assign ar_hs         = s_axi_arvalid & s_axi_arready;
   assign aw_hs         = s_axi_awvalid & s_axi_awready;
   assign hs_dir        = aw_hs ? DIR_WR : DIR_RD;

   // A full type FIFO withdraws valid so no descriptor escapes without its type word.
   assign req_valid    = in_burst & !type_fifo_full;
   assign fire         = req_valid & req_ready;
   assign last_beat    = (cnt_q == len_q);
   assign req_type     = in_burst ? (is_wr ? MSG_TYPE_STORE : MSG_TYPE_LOAD) : 2'd0;
   assign req_addr     = addr_q;
   assign req_last     = in_burst & last_beat;
   assign type_wr      = fire;
   assign type_wr_data = in_burst ? make_type_word(is_wr, last_beat, WIDE_BUS, NARROW_BUS & addr_q[3])
                                  : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         dir_q      <= DIR_RD;
         last_dir_q <= DIR_RD;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ar_hs || aw_hs) begin
                  dir_q  <= hs_dir;
                  addr_q <= aw_hs ? s_axi_awaddr : s_axi_araddr;
                  len_q  <= aw_hs ? s_axi_awlen : s_axi_arlen;
                  size_q <= aw_hs ? s_axi_awsize : s_axi_arsize;
                  cnt_q  <= '0;
                  // Direction turnaround waits for the response side to empty.
                  if ((hs_dir != last_dir_q) && !previous_trans_complete) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q <= (hs_dir == DIR_WR) ? ST_WR_BURST : ST_RD_BURST;
                  end
               end
            end
            ST_DRAIN: begin
               if (previous_trans_complete) begin
                  state_q <= (dir_q == DIR_WR) ? ST_WR_BURST : ST_RD_BURST;
               end
            end
            ST_RD_BURST, ST_WR_BURST: begin
               if (fire) begin
                  addr_q <= addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
                  if (last_beat) begin
                     state_q    <= ST_IDLE;
                     last_dir_q <= dir_q;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + AXI_LEN_WIDTH'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   ar_size_legal: assert property (@(posedge clk) disable iff (!rst_n)
      ar_hs |-> (s_axi_arsize <= 3'(MAX_SIZE)));
   aw_size_legal: assert property (@(posedge clk) disable iff (!rst_n)
      aw_hs |-> (s_axi_awsize <= 3'(MAX_SIZE)));

endmodule

// File: tb/tb_noc_axi_txn_scheduler.sv
// tb/tb_noc_axi_txn_scheduler.sv - self-checking bench for noc_axi_txn_scheduler
module tb_noc_axi_txn_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_axi_arvalid, s_axi_arready, s_axi_awvalid, s_axi_awready;
   logic [63:0] s_axi_araddr, s_axi_awaddr;
   logic [7:0]  s_axi_arlen, s_axi_awlen;
   logic [2:0]  s_axi_arsize, s_axi_awsize;
   logic        req_valid, req_ready, req_last, type_wr;
   logic [1:0]  req_type;
   logic [63:0] req_addr;
   logic [5:0]  type_wr_data;
   logic        type_fifo_full, previous_trans_complete;

   always #5 clk = ~clk;

   noc_axi_txn_scheduler #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(64), .AXI_LEN_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_addr(req_addr),
      .req_last(req_last), .type_wr(type_wr), .type_wr_data(type_wr_data),
      .type_fifo_full(type_fifo_full), .previous_trans_complete(previous_trans_complete)
   );

   typedef struct { logic [63:0] addr; logic [5:0] tw; logic last; logic [1:0] typ; } beat_t;
   typedef struct { logic [63:0] addr; logic [5:0] tw; logic last; int cyc; } fire_t;
   typedef struct { logic v; logic [63:0] addr; logic [7:0] len; logic [2:0] size; } pend_t;
   typedef struct {
      bit wr; logic [63:0] addr; logic [7:0] len; logic [2:0] size;
      logic [63:0] exp_last_addr; logic [5:0] exp_first_tw; logic [5:0] exp_last_tw; int exp_beats;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   beat_t exp_q[$];
   fire_t fire_log[$];
   int    hs_dir_log[$];
   int    hs_cyc_log[$];
   logic  m_drain, m_idle, m_exp_ar, m_exp_aw, m_exp_rv;
   bit    m_last_dir, m_rr_next, m_cur_dir;
   bit    mon_en = 1'b0;
   bit    rnd_mode = 1'b0;
   pend_t ar_p, aw_p;
   logic  ready_drv, full_drv, cmpl_drv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_drain    = 1'b0;
      m_last_dir = 1'b0;
      m_rr_next  = 1'b0;
      m_cur_dir  = 1'b0;
   endtask

   // Reference: a granted burst becomes len+1 beats computed straight from the address rules.
   task automatic add_burst(input bit dir, input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
      beat_t b;
      m_drain   = (dir != m_last_dir) && !previous_trans_complete;
      m_rr_next = !dir;
      m_cur_dir = dir;
      hs_dir_log.push_back(int'(dir));
      hs_cyc_log.push_back(cyc);
      for (int i = 0; i <= int'(len); i++) begin
         b.addr = addr + (64'(i) << size);
         b.last = (i == int'(len));
         b.typ  = dir ? 2'd2 : 2'd1;
         b.tw   = {dir && b.last, !dir && b.last, 1'b0, !dir && b.addr[3], b.typ};
         exp_q.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      beat_t b;
      #2;
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else if (mon_en) begin
         m_idle   = (exp_q.size() == 0);
         m_exp_ar = m_idle && s_axi_arvalid && (!s_axi_awvalid || !m_rr_next);
         m_exp_aw = m_idle && s_axi_awvalid && (!s_axi_arvalid || m_rr_next);
         m_exp_rv = !m_idle && !m_drain && !type_fifo_full;
         chk("arready", 64'(s_axi_arready), 64'(m_exp_ar));
         chk("awready", 64'(s_axi_awready), 64'(m_exp_aw));
         chk("req_valid", 64'(req_valid), 64'(m_exp_rv));
         if (req_valid && req_ready) begin
            chk("type_wr_on_fire", 64'(type_wr), 64'(1'b1));
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               chk("req_addr", req_addr, b.addr);
               chk("type_word", 64'(type_wr_data), 64'(b.tw));
               chk("req_last", 64'(req_last), 64'(b.last));
               chk("req_type", 64'(req_type), 64'(b.typ));
               if (b.last) m_last_dir = m_cur_dir;
            end else begin
               chk("fire_while_idle", 64'(exp_q.size()), 64'(1));
            end
            fire_log.push_back('{req_addr, type_wr_data, req_last, cyc});
         end else begin
            chk("type_wr_no_fire", 64'(type_wr), 64'(1'b0));
         end
         if (m_drain && previous_trans_complete) m_drain = 1'b0;
         if (s_axi_arvalid && s_axi_arready)      add_burst(1'b0, s_axi_araddr, s_axi_arlen, s_axi_arsize);
         else if (s_axi_awvalid && s_axi_awready) add_burst(1'b1, s_axi_awaddr, s_axi_awlen, s_axi_awsize);
      end
   end

   task automatic rand_pend(output pend_t p);
      p.v    = 1'b1;
      p.addr = {$urandom, $urandom};
      p.len  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
      p.size = 3'($urandom_range(0, 3));
   endtask

   task automatic cycle();
      @(negedge clk);
      if (rnd_mode) begin
         ready_drv = ($urandom_range(0, 3) != 0);
         full_drv  = ($urandom_range(0, 6) == 0);
         cmpl_drv  = ($urandom_range(0, 9) < 7);
         if (!ar_p.v && $urandom_range(0, 2) == 0) rand_pend(ar_p);
         if (!aw_p.v && $urandom_range(0, 2) == 0) rand_pend(aw_p);
      end
      s_axi_arvalid = ar_p.v; s_axi_araddr = ar_p.addr; s_axi_arlen = ar_p.len; s_axi_arsize = ar_p.size;
      s_axi_awvalid = aw_p.v; s_axi_awaddr = aw_p.addr; s_axi_awlen = aw_p.len; s_axi_awsize = aw_p.size;
      req_ready = ready_drv;
      type_fifo_full = full_drv;
      previous_trans_complete = cmpl_drv;
      #3;
      if (s_axi_arvalid && s_axi_arready) ar_p.v = 1'b0;
      if (s_axi_awvalid && s_axi_awready) aw_p.v = 1'b0;
   endtask

   task automatic wait_fires(input string name, input int n, input int bound);
      int k = 0;
      while (fire_log.size() < n && k < bound) begin
         cycle();
         k++;
      end
      chk(name, 64'(fire_log.size() >= n), 64'(1'b1));
   endtask

   task automatic set_pend(input bit wr, input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
      if (wr) aw_p = '{1'b1, addr, len, size};
      else    ar_p = '{1'b1, addr, len, size};
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ar_p = '{1'b0, 64'd0, 8'd0, 3'd0};
      aw_p = '{1'b0, 64'd0, 8'd0, 3'd0};
      repeat (3) cycle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t vecs[8];
   logic [63:0] hold_addr;
   bit hold_pending;
   int c0;

   initial begin
      rst_n = 1'b0;
      s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
      s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0;
      req_ready = 0; type_fifo_full = 0; previous_trans_complete = 0;
      ar_p = '{1'b0, 64'd0, 8'd0, 3'd0};
      aw_p = '{1'b0, 64'd0, 8'd0, 3'd0};
      ready_drv = 1'b1; full_drv = 1'b0; cmpl_drv = 1'b1;

      vecs[0] = '{1'b0, 64'h1000, 8'd3, 3'd3, 64'h1018, 6'h01, 6'h15, 4};
      vecs[1] = '{1'b1, 64'h2000, 8'd0, 3'd3, 64'h2000, 6'h22, 6'h22, 1};
      vecs[2] = '{1'b0, 64'h0008, 8'd0, 3'd3, 64'h0008, 6'h15, 6'h15, 1};
      vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 64'h0, 6'h05, 6'h11, 2};
      vecs[4] = '{1'b1, 64'h3000, 8'd2, 3'd1, 64'h3004, 6'h02, 6'h22, 3};
      vecs[5] = '{1'b0, 64'h4004, 8'd3, 3'd2, 64'h4010, 6'h01, 6'h11, 4};
      vecs[6] = '{1'b1, 64'h5008, 8'd1, 3'd3, 64'h5010, 6'h02, 6'h22, 2};
      vecs[7] = '{1'b0, 64'h0010, 8'd255, 3'd0, 64'h010F, 6'h01, 6'h15, 256};

      #12;
      chk("rst_arready", 64'(s_axi_arready), 64'(1'b0));
      chk("rst_awready", 64'(s_axi_awready), 64'(1'b0));
      chk("rst_req_valid", 64'(req_valid), 64'(1'b0));
      chk("rst_type_wr", 64'(type_wr), 64'(1'b0));
      chk("rst_req_addr", req_addr, 64'd0);
      chk("rst_type_data", 64'(type_wr_data), 64'd0);
      chk("rst_req_last", 64'(req_last), 64'(1'b0));
      mon_en = 1'b1;
      apply_reset();

      // Table-driven bursts, each run to completion with ready=1 and no drain.
      foreach (vecs[i]) begin
         fire_log.delete();
         set_pend(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].size);
         wait_fires("vec_timeout", vecs[i].exp_beats, vecs[i].exp_beats + 10);
         repeat (2) cycle();
         chk("vec_beats", 64'(fire_log.size()), 64'(vecs[i].exp_beats));
         if (fire_log.size() > 0) begin
            chk("vec_first_tw", 64'(fire_log[0].tw), 64'(vecs[i].exp_first_tw));
            chk("vec_last_addr", fire_log[fire_log.size()-1].addr, vecs[i].exp_last_addr);
            chk("vec_last_tw", 64'(fire_log[fire_log.size()-1].tw), 64'(vecs[i].exp_last_tw));
            chk("vec_last_flag", 64'(fire_log[fire_log.size()-1].last), 64'(1'b1));
            chk("vec_latency", 64'(fire_log[0].cyc - hs_cyc_log[hs_cyc_log.size()-1]), 64'd1);
            if (vecs[i].exp_beats > 1) chk("vec_not_last_early", 64'(fire_log[0].last), 64'(1'b0));
         end
      end

      // Write then read with the response side busy: read waits in DRAIN.
      fire_log.delete();
      set_pend(1'b1, 64'h2000, 8'd0, 3'd3);
      wait_fires("drain_aw_timeout", 1, 10);
      if (fire_log.size() > 0) chk("aw_type_word", 64'(fire_log[0].tw), 64'h22);
      cmpl_drv = 1'b0;
      set_pend(1'b0, 64'h3008, 8'd0, 3'd3);
      repeat (6) cycle();
      chk("drain_accepted", 64'(ar_p.v), 64'(1'b0));
      chk("drain_hold", 64'(fire_log.size()), 64'd1);
      cmpl_drv = 1'b1;
      cycle();
      c0 = cyc;
      chk("drain_no_valid_on_release", 64'(req_valid), 64'(1'b0));
      wait_fires("drain_rd_timeout", 2, 5);
      if (fire_log.size() > 1) begin
         chk("drain_release_latency", 64'(fire_log[1].cyc - c0), 64'd1);
         chk("drain_rd_tw", 64'(fire_log[1].tw), 64'h15);
      end

      // AR and AW always valid from reset: grants alternate R, W, R, W.
      apply_reset();
      hs_dir_log.delete();
      for (int k = 0; k < 60 && hs_dir_log.size() < 4; k++) begin
         if (!ar_p.v) set_pend(1'b0, 64'h8000 + 64'(k * 64), 8'd1, 3'd3);
         if (!aw_p.v) set_pend(1'b1, 64'h9000 + 64'(k * 64), 8'd1, 3'd3);
         cycle();
      end
      chk("alt_grants", 64'(hs_dir_log.size()), 64'd4);
      for (int k = 0; k < 4 && k < hs_dir_log.size(); k++)
         chk("alt_dir", 64'(hs_dir_log[k]), 64'(k % 2));
      for (int k = 0; k < 40 && (ar_p.v || aw_p.v || exp_q.size() != 0); k++) cycle();
      chk("alt_settled", 64'(exp_q.size()), 64'd0);

      // Type FIFO full mid-burst for 3 cycles.
      fire_log.delete();
      set_pend(1'b0, 64'h4000, 8'd5, 3'd3);
      wait_fires("full_pre_timeout", 2, 10);
      full_drv = 1'b1;
      repeat (3) begin
         cycle();
         chk("full_req_valid", 64'(req_valid), 64'(1'b0));
         chk("full_type_wr", 64'(type_wr), 64'(1'b0));
         chk("full_addr_hold", req_addr, 64'h4010);
      end
      full_drv = 1'b0;
      wait_fires("full_post_timeout", 6, 12);
      repeat (2) cycle();
      chk("full_beats", 64'(fire_log.size()), 64'd6);
      if (fire_log.size() > 2) chk("full_resume_addr", fire_log[2].addr, 64'h4010);

      // req_ready toggling: descriptor stable while stalled.
      fire_log.delete();
      set_pend(1'b1, 64'h5000, 8'd4, 3'd2);
      hold_pending = 1'b0;
      for (int k = 0; k < 40 && fire_log.size() < 5; k++) begin
         ready_drv = k[0];
         cycle();
         if (hold_pending) begin
            chk("stall_valid_kept", 64'(req_valid), 64'(1'b1));
            chk("stall_addr_kept", req_addr, hold_addr);
         end
         hold_pending = req_valid && !req_ready;
         hold_addr = req_addr;
      end
      ready_drv = 1'b1;
      repeat (3) cycle();
      chk("toggle_type_wr_count", 64'(fire_log.size()), 64'd5);
      if (fire_log.size() > 4) chk("toggle_last_addr", fire_log[4].addr, 64'h5010);

      // Asynchronous reset during beat 2 of a len=7 burst.
      fire_log.delete();
      set_pend(1'b0, 64'h6000, 8'd7, 3'd3);
      wait_fires("rst_pre_timeout", 2, 10);
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_req_valid", 64'(req_valid), 64'(1'b0));
      chk("arst_type_wr", 64'(type_wr), 64'(1'b0));
      chk("arst_req_addr", req_addr, 64'd0);
      chk("arst_type_data", 64'(type_wr_data), 64'd0);
      chk("arst_req_last", 64'(req_last), 64'(1'b0));
      chk("arst_req_type", 64'(req_type), 64'd0);
      chk("arst_readies", 64'({s_axi_arready, s_axi_awready}), 64'd0);
      apply_reset();
      fire_log.delete();
      set_pend(1'b0, 64'h7000, 8'd1, 3'd3);
      wait_fires("rst_post_timeout", 2, 10);
      if (fire_log.size() > 1) begin
         chk("arst_restart_addr", fire_log[0].addr, 64'h7000);
         chk("arst_restart_first_last", 64'(fire_log[0].last), 64'(1'b0));
         chk("arst_restart_end", 64'(fire_log[1].last), 64'(1'b1));
      end

      // Randomized traffic against the reference model.
      rnd_mode = 1'b1;
      repeat (3000) cycle();
      rnd_mode = 1'b0;
      ready_drv = 1'b1; full_drv = 1'b0; cmpl_drv = 1'b1;
      for (int k = 0; k < 600 && (ar_p.v || aw_p.v || exp_q.size() != 0); k++) cycle();
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_pend_accepted", 64'({ar_p.v, aw_p.v}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
